// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-port memory.
// Round-robin grant, one outstanding transaction, with a bounded wait for m_ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; a pending request is granted on the next edge
// BUSY  | command presented on m_*, waiting for m_ready or timeout
// RESP  | ack (and err) of the granted port is high for this one cycle
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,

  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_grant;  // 1 = data port won the most recent grant
  logic       grant_d;     // port owning the current transaction
  logic [7:0] cnt;
  logic       pick_d;
  logic       done;

  // Data wins when it is alone, or when both request and instruction won last.
  always_comb begin
    pick_d = d_req & (~i_req | ~last_grant);
  end

  always_comb begin
    done = m_ready | (cnt == CNT_TC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      grant_d    <= 1'b0;
      cnt        <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state      <= BUSY;
            m_req      <= 1'b1;
            cnt        <= '0;
            grant_d    <= pick_d;
            last_grant <= pick_d;
            if (pick_d) begin
              m_we    <= d_we;
              m_be    <= d_be;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_be    <= 4'hF;
              m_addr  <= i_addr;
              m_wdata <= '0;
            end
          end
        end

        BUSY: begin
          if (done) begin
            // m_ready wins over the timeout when both hit on the same edge
            state <= RESP;
            m_req <= 1'b0;
            if (grant_d) begin
              d_ack   <= 1'b1;
              d_err   <= ~m_ready;
              d_rdata <= m_ready ? m_rdata : '0;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= ~m_ready;
              i_rdata <= m_ready ? m_rdata : '0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          state <= IDLE;
          i_ack <= 1'b0;
          i_err <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
        end

        default: begin
          state <= IDLE;
          m_req <= 1'b0;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks against
// hand-computed values; inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  int n_cmp;
  int n_bad;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
    n_cmp++; if ({m_we, m_be} !== 5'b0) begin n_bad++; $display("FAIL reset_m_we_be: got %b expected 0", {m_we, m_be}); end
    n_cmp++; if ({m_addr, m_wdata} !== 64'h0) begin n_bad++; $display("FAIL reset_m_addr_wdata: got %h expected 0", {m_addr, m_wdata}); end
    n_cmp++; if ({i_ack, i_err, d_ack, d_err} !== 4'b0) begin n_bad++; $display("FAIL reset_ack_err: got %b expected 0000", {i_ack, i_err, d_ack, d_err}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: got m_req=%b expected 0", m_req); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h100; m_ready = 1'b1; m_rdata = 32'h2402000A;
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL fetch_m_req: got %b expected 1", m_req); end
    n_cmp++; if (m_we !== 1'b0 || m_be !== 4'hF) begin n_bad++; $display("FAIL fetch_we_be: got %b/%h expected 0/f", m_we, m_be); end
    n_cmp++; if (m_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_m_addr: got %h expected 100", m_addr); end
    n_cmp++; if (i_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ack: got %b expected 0", i_ack); end
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL fetch_m_req_one_cycle: got %b expected 0", m_req); end
    n_cmp++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_ack: got i=%b d=%b expected i=1 d=0", i_ack, d_ack); end
    n_cmp++; if (i_rdata !== 32'h2402000A) begin n_bad++; $display("FAIL fetch_rdata: got %h expected 2402000a", i_rdata); end
    n_cmp++; if (i_err !== 1'b0) begin n_bad++; $display("FAIL fetch_err: got %b expected 0", i_err); end
    i_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_ack !== 1'b0 || m_req !== 1'b0) begin n_bad++; $display("FAIL fetch_ack_pulse: got ack=%b m_req=%b expected 0 0", i_ack, m_req); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF; d_wdata = 32'h0;
    m_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'h300) begin n_bad++; $display("FAIL simul_first_grant: got m_req=%b addr=%h expected 1 300", m_req, m_addr); end
    m_ready = 1'b1; m_rdata = 32'h11;
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin n_bad++; $display("FAIL simul_d_ack: got d=%b i=%b expected d=1 i=0", d_ack, i_ack); end
    n_cmp++; if (d_rdata !== 32'h11) begin n_bad++; $display("FAIL simul_d_rdata: got %h expected 11", d_rdata); end
    d_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b0 || d_ack !== 1'b0) begin n_bad++; $display("FAIL simul_idle: got m_req=%b d_ack=%b expected 0 0", m_req, d_ack); end
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'h200 || m_we !== 1'b0) begin n_bad++; $display("FAIL simul_second_grant: got m_req=%b addr=%h we=%b expected 1 200 0", m_req, m_addr, m_we); end
    m_ready = 1'b1; m_rdata = 32'h22;
    @(negedge clk);
    n_cmp++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin n_bad++; $display("FAIL simul_i_ack: got i=%b d=%b expected i=1 d=0", i_ack, d_ack); end
    n_cmp++; if (i_rdata !== 32'h22 || d_rdata !== 32'h11) begin n_bad++; $display("FAIL simul_rdata_hold: got i=%h d=%h expected 22 11", i_rdata, d_rdata); end
    i_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_ack !== 1'b0) begin n_bad++; $display("FAIL simul_i_ack_pulse: got %b expected 0", i_ack); end
  endtask

  task automatic test_store_delay();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    m_ready = 1'b0; m_rdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_be !== 4'b0011 || m_addr !== 32'h40 || m_wdata !== 32'hDEADBEEF || d_ack !== 1'b0) begin
        n_bad++;
        $display("FAIL store_busy_cycle%0d: got req=%b we=%b be=%b addr=%h wdata=%h ack=%b expected 1 1 0011 40 deadbeef 0", k, m_req, m_we, m_be, m_addr, m_wdata, d_ack);
      end
      if (k == 4) m_ready = 1'b1;
    end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || d_err !== 1'b0 || m_req !== 1'b0) begin n_bad++; $display("FAIL store_ack: got ack=%b err=%b m_req=%b expected 1 0 0", d_ack, d_err, m_req); end
    d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b0) begin n_bad++; $display("FAIL store_ack_pulse: got %b expected 0", d_ack); end
  endtask

  task automatic test_timeout();
    int busy;
    busy = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
    m_ready = 1'b0; m_rdata = 32'h55555555;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_ack) break;
      if (m_req) busy++;
    end
    n_cmp++; if (busy !== 15) begin n_bad++; $display("FAIL timeout_busy_cycles: got %0d expected 15", busy); end
    n_cmp++; if (d_ack !== 1'b1 || d_err !== 1'b1) begin n_bad++; $display("FAIL timeout_ack_err: got ack=%b err=%b expected 1 1", d_ack, d_err); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL timeout_rdata: got %h expected 0", d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b0) begin n_bad++; $display("FAIL timeout_ack_pulse: got %b expected 0", d_ack); end
    d_req = 1'b1; d_addr = 32'h84; m_ready = 1'b1; m_rdata = 32'h77;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h77) begin n_bad++; $display("FAIL after_timeout_normal: got ack=%b err=%b rdata=%h expected 1 0 77", d_ack, d_err, d_rdata); end
    d_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout_boundary();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88; m_ready = 1'b0; m_rdata = 32'h0BADF00D;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 15) begin
        n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL boundary_still_busy: got %b expected 1", m_req); end
        m_ready = 1'b1;
      end
    end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL boundary_ready_wins: got ack=%b err=%b rdata=%h expected 1 0 0badf00d", d_ack, d_err, d_rdata); end
    d_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90; m_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL midrst_busy: got %b expected 1", m_req); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL midrst_m_req_drop: got %b expected 0", m_req); end
    d_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if ({m_req, i_ack, d_ack} !== 3'b000) begin n_bad++; $display("FAIL midrst_no_ack%0d: got %b expected 000", k, {m_req, i_ack, d_ack}); end
    end
    i_req = 1'b1; i_addr = 32'h194; d_req = 1'b1; d_addr = 32'h94;
    @(negedge clk);
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 32'h94) begin n_bad++; $display("FAIL midrst_d_first: got m_req=%b addr=%h expected 1 94", m_req, m_addr); end
    m_ready = 1'b1; m_rdata = 32'hABCD;
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin n_bad++; $display("FAIL midrst_d_ack: got d=%b i=%b expected 1 0", d_ack, i_ack); end
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternation();
    logic g [8];
    logic exp_g [8];
    logic prev_mreq;
    logic cur_d;
    logic d_low;
    int   ng;
    for (int k = 0; k < 8; k++) begin g[k] = 1'bx; exp_g[k] = (k % 2 == 1); end
    ng = 0; prev_mreq = 1'b0; cur_d = 1'b0; d_low = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_addr = 32'h2000; d_we = 1'b0;
    m_ready = 1'b1; m_rdata = 32'h5A5A;
    for (int k = 0; k < 40 && ng < 8; k++) begin
      @(negedge clk);
      if (m_req && !prev_mreq) begin
        cur_d = (m_addr == 32'h2000);
        g[ng] = cur_d;
        ng++;
      end
      prev_mreq = m_req;
      if (i_ack || d_ack) begin
        n_cmp++; if ({i_ack, d_ack} !== {~cur_d, cur_d}) begin n_bad++; $display("FAIL alt_ack_port: got i=%b d=%b expected d=%b", i_ack, d_ack, cur_d); end
      end
      if (d_ack) begin d_req = 1'b0; d_low = 1'b1; end
      else if (d_low) begin d_req = 1'b1; d_low = 1'b0; end
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (g[k] !== exp_g[k]) begin n_bad++; $display("FAIL alt_grant%0d: got %b expected %b (1=data)", k, g[k], exp_g[k]); end
    end
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    clk = 1'b0; rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store_delay();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_busy();
    test_alternation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
